// File: rtl/usr_seq_pkg.sv
// usr_seq_pkg: shared state/op encodings and direction constants for the shift sequencer
package usr_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_SHL, OP_SHR} dp_op_e;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/usr_shift_datapath.sv
// usr_shift_datapath: WIDTH-bit register (clk, reset, op, d in; q out) with hold/load/zero-fill shift left/right
module usr_shift_datapath
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  dp_op_e           op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q, r_d;
  always_comb
    r_d = op == OP_LOAD ? d :
          op == OP_SHL  ? {r_q[WIDTH-2:0], 1'b0} :
          op == OP_SHR  ? {1'b0, r_q[WIDTH-1:1]} : r_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  assign q = r_q;
endmodule

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: accepts cmd (data/dir/count) on cmd_valid/ready, loads and shifts the datapath count times, returns rsp_data on rsp_valid/ready; busy outside IDLE
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  state_e           state_q, state_d;
  dp_op_e           dp_op;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rem_q, rem_d, cnt_sat;
  logic             accept;
  assign accept = cmd_valid && state_q == ST_IDLE;
  // only reachable for non-power-of-two WIDTH, where WIDTH itself fits in CNT_W bits
  assign cnt_sat = {1'b0, cmd_count} >= (CNT_W+1)'(WIDTH) ? CNT_W'(WIDTH) : cmd_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = cmd_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = cnt_q == '0 ? ST_DONE : ST_SHIFT;
      ST_SHIFT: state_d = rem_q == CNT_W'(1) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = rsp_ready ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    data_d = accept ? cmd_data : data_q;
    dir_d  = accept ? cmd_dir : dir_q;
    cnt_d  = accept ? cnt_sat : cnt_q;
    rem_d  = state_q == ST_LOAD  ? cnt_q :
             state_q == ST_SHIFT ? rem_q - 1'b1 : rem_q;
  end
  always_comb begin
    dp_op     = state_q == ST_LOAD  ? OP_LOAD :
                state_q == ST_SHIFT ? (dir_q == DIR_RIGHT ? OP_SHR : OP_SHL) : OP_HOLD;
    cmd_ready = state_q == ST_IDLE && !reset;
    rsp_valid = state_q == ST_DONE;
    busy      = state_q != ST_IDLE;
  end
  usr_shift_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .reset (reset),
    .op    (dp_op),
    .d     (data_q),
    .q     (rsp_data)
  );
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer: vector table, hand-written corner sequences and random commands against a shift model
module tb_usr_shift_sequencer;
  import usr_seq_pkg::*;
  logic       clk = 0, reset = 1;
  logic       cmd_valid = 0, cmd_dir = 0, rsp_ready = 0;
  logic [7:0] cmd_data = '0;
  logic [2:0] cmd_count = '0;
  logic       cmd_ready, rsp_valid, busy;
  logic [7:0] rsp_data;
  int         total = 0, bad = 0, shl_n = 0, shr_n = 0, cyc = 0;
  int         acc_q[$];
  logic [7:0] rsp_q[$];
  typedef struct {
    logic [7:0] d;
    logic       dir;
    logic [2:0] c;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[8];
  usr_shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.dp_op == OP_SHL) shl_n <= shl_n + 1;
    if (dut.dp_op == OP_SHR) shr_n <= shr_n + 1;
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
  end
  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] model(input logic [7:0] d, input logic dir, input logic [2:0] c);
    int unsigned x = d;
    return dir ? 8'(x >> c) : 8'(x << c);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic run_cmd(input logic [7:0] d, input logic dir, input logic [2:0] c,
                         input int hold, input bit poke, input logic [7:0] exp);
    int k, lat;
    @(negedge clk);
    cmd_valid = 1; cmd_data = d; cmd_dir = dir; cmd_count = c;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept_wait", k < 50, 1);
    shl_n = 0; shr_n = 0;
    @(negedge clk);
    cmd_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("latency", lat, c + 1);
    chk("rsp_data", rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin cmd_valid = 1; cmd_data = 8'hFF; end
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp);
      if (poke) chk("hold_ready_busy", {cmd_ready, busy}, 2'b01);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_after", {busy, cmd_ready, rsp_valid}, 3'b010);
    chk("shl_ops", shl_n, dir ? 0 : c);
    chk("shr_ops", shr_n, dir ? c : 0);
  endtask
  initial begin
    int k, gap;
    logic [7:0] d;
    logic       dir;
    logic [2:0] c;
    vt[0] = '{8'hB5, DIR_LEFT,  3'd3, 8'hA8};
    vt[1] = '{8'hB5, DIR_RIGHT, 3'd2, 8'h2D};
    vt[2] = '{8'h81, DIR_LEFT,  3'd0, 8'h81};
    vt[3] = '{8'h81, DIR_LEFT,  3'd7, 8'h80};
    vt[4] = '{8'h01, DIR_RIGHT, 3'd1, 8'h00};
    vt[5] = '{8'h80, DIR_LEFT,  3'd1, 8'h00};
    vt[6] = '{8'hFF, DIR_RIGHT, 3'd7, 8'h01};
    vt[7] = '{8'h3C, DIR_LEFT,  3'd2, 8'hF0};
    #1;
    chk("rst_outputs", {cmd_ready, rsp_valid, busy, rsp_data}, 11'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("post_rst", {cmd_ready, rsp_valid, busy, rsp_data}, {3'b100, 8'h00});
    foreach (vt[i]) run_cmd(vt[i].d, vt[i].dir, vt[i].c, 0, 0, vt[i].exp);
    run_cmd(8'h6E, DIR_RIGHT, 3'd4, 5, 1, 8'h06);
    @(negedge clk);
    cmd_valid = 1; cmd_data = 8'hFF; cmd_dir = DIR_LEFT; cmd_count = 3'd6;
    @(posedge clk);
    #1 cmd_valid = 0;
    repeat (3) @(posedge clk);
    #2 chk("pre_rst_data", rsp_data, 8'hFC);
    reset = 1;
    #1 chk("mid_rst", {cmd_ready, rsp_valid, busy, rsp_data}, 11'h0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", {rsp_valid, busy}, 2'b00);
    reset = 0;
    @(negedge clk);
    chk("after_abort", {cmd_ready, rsp_valid, busy}, 3'b100);
    run_cmd(8'h5A, DIR_RIGHT, 3'd3, 0, 0, 8'h0B);
    acc_q.delete(); rsp_q.delete();
    @(negedge clk);
    rsp_ready = 1; cmd_valid = 1; cmd_data = 8'hC3; cmd_dir = DIR_LEFT; cmd_count = 3'd2;
    k = 0;
    while (acc_q.size() < 1 && k < 50) begin @(negedge clk); k++; end
    cmd_data = 8'h96; cmd_dir = DIR_RIGHT; cmd_count = 3'd5;
    k = 0;
    while (acc_q.size() < 2 && k < 50) begin @(negedge clk); k++; end
    cmd_valid = 0;
    k = 0;
    while (rsp_q.size() < 2 && k < 50) begin @(negedge clk); k++; end
    rsp_ready = 0;
    gap = acc_q.size() == 2 ? acc_q[1] - acc_q[0] : -1;
    chk("b2b_gap", gap, 5);
    chk("b2b_rsp_n", rsp_q.size(), 2);
    chk("b2b_rsp0", rsp_q.size() > 0 ? rsp_q[0] : 8'hXX, model(8'hC3, DIR_LEFT, 3'd2));
    chk("b2b_rsp1", rsp_q.size() > 1 ? rsp_q[1] : 8'hXX, model(8'h96, DIR_RIGHT, 3'd5));
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom_range(0, 255));
      dir = 1'($urandom_range(0, 1));
      c   = 3'($urandom_range(0, 7));
      run_cmd(d, dir, c, int'($urandom_range(0, 3)), 0, model(d, dir, c));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usr_shift_sequencer.md
# usr_shift_sequencer

Command-driven sequencer for the team's 8-bit universal shift datapath. It accepts one command per transaction over a valid/ready handshake: a data byte, a direction and a shift count. It loads the byte, issues exactly the requested number of single-bit shifts, then returns the result over a second valid/ready handshake. It sits between a register-mapped or FSM requester and the shift datapath, which it owns exclusively.

## Interface
- WIDTH, 8, datapath width in bits
- CNT_W, $clog2(WIDTH), shift-count field width; legal counts are 0..WIDTH-1
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
- cmd_data  input  WIDTH  byte to load
- cmd_dir  input  1  0 = shift left (toward MSB), 1 = shift right
- cmd_count  input  CNT_W  number of single-bit shifts
- rsp_valid  output  1  result available
- rsp_ready  input  1  requester accepts result
- rsp_data  output  WIDTH  shifted result
- busy  output  1  high in LOAD, SHIFT and DONE

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture data, dir and count into command registers, then go to LOAD.
- LOAD:
  - Datapath op=LOAD, with the captured byte.
  - If count==0, go to DONE; otherwise go to SHIFT with remaining=count.
- SHIFT:
  - Datapath op=SHL (dir=0) or SHR (dir=1) every cycle; remaining decrements.
  - When remaining==1 at the edge, go to DONE.
- DONE:
  - rsp_valid=1; rsp_data is the datapath register, held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Datapath ops: HOLD, LOAD, SHL, SHR.
  - Vacated bit is filled with 0 (SHL: {r[W-2:0],0}; SHR: {0,r[W-1:1]}).
  - HOLD retains the value. The sequencer uses HOLD in IDLE and DONE, so the register never changes outside LOAD/SHIFT.
- cmd_valid outside IDLE is ignored; no command is queued. Requester must hold cmd_valid/cmd_data until accepted.
- cmd_count >= WIDTH cannot occur for power-of-two WIDTH. Otherwise, saturate to WIDTH (result 0).
- Reset values: cmd_ready=0 during reset and 1 after release (state IDLE); rsp_valid=0; rsp_data=0; busy=0; datapath register=0; remaining=0.
- Reset asserted mid-transaction aborts it. No response is issued and state returns to IDLE.

## Timing
- Accept at edge E0. Load at E1. Shifts at E2..E(count+1).
- rsp_valid is high from just after edge E(count+1): count 0 → after E1, count 7 → after E8.
- rsp_valid stays high, with rsp_data unchanged, until a rsp_ready handshake edge. Then IDLE at that edge; cmd_ready=1 the following cycle.
- Minimum command-to-command spacing with rsp_ready tied high is count+3 cycles.
- Outputs are registered or decoded from state only; no combinational path from cmd_* or rsp_ready to any output.

## Structure
- Package usr_seq_pkg:
  - state enum (IDLE/LOAD/SHIFT/DONE);
  - datapath op enum (HOLD/LOAD/SHL/SHR, 2 bits);
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, usr_shift_datapath:
  - WIDTH-bit register with op input;
  - asynchronous active-high reset;
  - zero-fill shifts;
  - parallel output.
- FSM, command registers and down-counter live in usr_shift_sequencer.

## Test plan
- Data 0xB5, dir left, count 3 → rsp_data 0xA8; rsp_valid rises 4 edges after accept edge.
- Data 0xB5, dir right, count 2 → rsp_data 0x2D; exactly 2 SHR ops observed on the datapath op.
- Data 0x81, count 0 → rsp_data 0x81 one edge after accept; left count 7 on 0x81 → 0x80.
- Backpressure: rsp_ready low 5 cycles after rsp_valid → rsp_data stable, cmd_ready low, busy high. A new cmd_valid=1 (data 0xFF) during this period is not accepted.
- Reset asserted asynchronously during SHIFT (0xFF, left, 6, after 2 shifts) → outputs immediately at reset values, no response. The next command completes correctly.
- Back-to-back: rsp_ready tied high, cmd_valid held with a second command → second accept occurs count+3 cycles after the first; both results correct.
